// File: rtl/mfcc_delta_framer.sv
// mfcc_delta_framer: keeps a six-frame history of MFCC coefficients and, for
// every centre frame t, streams 12 static coefficients followed by 12
// first-order deltas 2*(c[t+2]-c[t-2]) + (c[t+1]-c[t-1]) on a valid/ready port.
// Optional build macro VAD_GATE_EN: suppresses vectors whose centre frame was
// marked as non-speech (the elements still step through, with dv_out held low).
module mfcc_delta_framer #(
    parameter int NCEP  = 12,
    parameter int W     = 32,
    parameter int NSLOT = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] x_i,
    input  logic [4:0]          in_index,
    input  logic                dv_in,
    input  logic                vad_in,
    output logic signed [W+2:0] feat_o,
    output logic [4:0]          out_index,
    output logic                dv_out,
    input  logic                out_ready,
    output logic                busy,
    output logic                overrun
);

    localparam int CIW   = $clog2(NCEP);
    localparam int NFEAT = 2 * NCEP;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DONE
    } state_t;

    // Slot pointer arithmetic modulo the number of history slots.
    function automatic logic [2:0] slotBack(input logic [2:0] base, input logic [2:0] n);
        return (base >= n) ? (base - n) : (base + 3'(NSLOT) - n);
    endfunction

    function automatic logic [2:0] slotNext(input logic [2:0] s);
        return (s == 3'(NSLOT - 1)) ? 3'd0 : (s + 3'd1);
    endfunction

    function automatic logic signed [W+2:0] sext(input logic signed [W-1:0] v);
        return {{3{v[W-1]}}, v};
    endfunction

    logic signed [W-1:0] coefMem [NSLOT][NCEP];

    state_t              state_q;
    logic [2:0]          wrSlot_q, wrSlot_d;
    logic [2:0]          framesFilled_q, framesFilled_d;
    logic                pending_q, pending_d;
    logic                trigger_q;
    logic                dropping_q;
    logic                overrun_q;
    logic                suppress_q;
    logic                suppressNext;
    logic [2:0]          ptrTm2_q, ptrTm1_q, ptrT_q, ptrTp1_q, ptrTp2_q;
    logic [4:0]          elem_q;
    logic signed [W+2:0] feat_q;
    logic [4:0]          outIndex_q;
    logic                dvOut_q;
    logic                busy_q;

    logic                sampleValid, isLast, blocked, writeEn;
    logic                completeOk, completeDrop, triggerNow, launching, advance;
    logic [CIW-1:0]      coefIdx;
    logic signed [W+2:0] eTm2, eTm1, eT, eTp1, eTp2, featNext;

    // A sample is blocked when the only free slot already holds a pending
    // frame, or when an earlier sample of the same frame was already dropped.
    assign sampleValid  = dv_in && (in_index < 5'(NCEP));
    assign isLast       = (in_index == 5'(NCEP - 1));
    assign blocked      = dropping_q || (pending_q && (state_q != IDLE));
    assign writeEn      = sampleValid && !blocked;
    assign completeOk   = writeEn && isLast;
    assign completeDrop = sampleValid && blocked && isLast;
    assign triggerNow   = completeOk && (framesFilled_q >= 3'd4);
    assign launching    = ((state_q == IDLE) && (trigger_q || pending_q)) ||
                          ((state_q == DONE) && pending_q);
    assign advance      = suppress_q || !dvOut_q || out_ready;

`ifdef VAD_GATE_EN
    logic vadMem [NSLOT];

    assign suppressNext = ~vadMem[slotBack(wrSlot_q, 3'd3)];

    // Voice-activity bit of each frame, captured when the frame completes.
    always_ff @(posedge clk) begin
        if (completeOk) begin
            vadMem[wrSlot_q] <= vad_in;
        end
    end
`else
    logic unusedVad;

    assign unusedVad    = vad_in;
    assign suppressNext = 1'b0;
`endif

    // Next-state values for the history bookkeeping and the pending flag.
    always_comb begin
        wrSlot_d       = wrSlot_q;
        framesFilled_d = framesFilled_q;
        pending_d      = pending_q && !launching;
        if (completeOk) begin
            wrSlot_d       = slotNext(wrSlot_q);
            framesFilled_d = (framesFilled_q == 3'd5) ? 3'd5 : (framesFilled_q + 3'd1);
        end
        if (triggerNow && !((state_q == IDLE) && !launching)) begin
            pending_d = 1'b1;
        end
    end

    // Coefficient storage, written by index into the current free slot.
    always_ff @(posedge clk) begin
        if (writeEn) begin
            coefMem[wrSlot_q][in_index[CIW-1:0]] <= x_i;
        end
    end

    // History bookkeeping: write slot, fill level, frame-drop tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrSlot_q       <= 3'd0;
            framesFilled_q <= 3'd0;
            dropping_q     <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            wrSlot_q       <= wrSlot_d;
            framesFilled_q <= framesFilled_d;
            if (sampleValid) begin
                if (isLast) begin
                    dropping_q <= 1'b0;
                end else if (blocked) begin
                    dropping_q <= 1'b1;
                end
            end
            if (completeDrop) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Feature element for the current position: static value or delta.
    always_comb begin
        if (elem_q < 5'(NCEP)) begin
            coefIdx = elem_q[CIW-1:0];
        end else begin
            coefIdx = CIW'(elem_q - 5'(NCEP));
        end
        eTm2 = sext(coefMem[ptrTm2_q][coefIdx]);
        eTm1 = sext(coefMem[ptrTm1_q][coefIdx]);
        eT   = sext(coefMem[ptrT_q][coefIdx]);
        eTp1 = sext(coefMem[ptrTp1_q][coefIdx]);
        eTp2 = sext(coefMem[ptrTp2_q][coefIdx]);
        if (elem_q < 5'(NCEP)) begin
            featNext = eT;
        end else begin
            featNext = ((eTp2 - eTm2) <<< 1) + (eTp1 - eTm1);
        end
    end

    // Emit sequencer: latches the window on launch and walks the 24 elements
    // with registered valid/data held until each element is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            trigger_q  <= 1'b0;
            suppress_q <= 1'b0;
            elem_q     <= 5'd0;
            ptrTm2_q   <= 3'd0;
            ptrTm1_q   <= 3'd0;
            ptrT_q     <= 3'd0;
            ptrTp1_q   <= 3'd0;
            ptrTp2_q   <= 3'd0;
            feat_q     <= '0;
            outIndex_q <= 5'd0;
            dvOut_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            trigger_q <= triggerNow && (state_q == IDLE) && !launching;
            if (launching) begin
                state_q    <= EMIT;
                busy_q     <= 1'b1;
                elem_q     <= 5'd0;
                suppress_q <= suppressNext;
                ptrTp2_q   <= slotBack(wrSlot_q, 3'd1);
                ptrTp1_q   <= slotBack(wrSlot_q, 3'd2);
                ptrT_q     <= slotBack(wrSlot_q, 3'd3);
                ptrTm1_q   <= slotBack(wrSlot_q, 3'd4);
                ptrTm2_q   <= slotBack(wrSlot_q, 3'd5);
            end else begin
                case (state_q)
                    EMIT: begin
                        if (advance) begin
                            if (elem_q < 5'(NFEAT)) begin
                                dvOut_q    <= !suppress_q;
                                feat_q     <= featNext;
                                outIndex_q <= elem_q;
                                elem_q     <= elem_q + 5'd1;
                            end else begin
                                dvOut_q <= 1'b0;
                                busy_q  <= 1'b0;
                                state_q <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign feat_o    = feat_q;
    assign out_index = outIndex_q;
    assign dv_out    = dvOut_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/mfcc_delta_framer.md
Name: mfcc_delta_framer

Overview:
- Sits directly downstream of the MFCC extractor on the `sclk` domain.
- Consumes the 12-coefficient-per-frame MFCC stream (value, index, data-valid, vad) and keeps a 6-slot frame history.
- For each centre frame, emits a 24-element feature vector: 12 static coefficients, then 12 first-order delta coefficients.
- Output is a valid/ready stream feeding the DNN input buffer.

Parameters:
- NCEP, 12, cepstral coefficients per frame; `in_index` 0..NCEP-1.
- W, 32, input coefficient width (signed).
- NSLOT, 6, frame history slots; fixed at 6 (window ±2 plus one free write slot).

Ports:
- clk  in  1  processing clock (driven by the MFCC `sclk`).
- rst  in  1  synchronous, active-high reset.
- x_i  in  W  signed MFCC coefficient.
- in_index  in  5  coefficient index of `x_i`.
- dv_in  in  1  `x_i`/`in_index` valid this cycle.
- vad_in  in  1  voice-activity flag, sampled at frame completion.
- feat_o  out  W+3  signed feature value (static values sign-extended).
- out_index  out  5  feature index 0..2*NCEP-1.
- dv_out  out  1  `feat_o` valid.
- out_ready  in  1  downstream accepts `feat_o` when `dv_out & out_ready`.
- busy  out  1  high in EMIT.
- overrun  out  1  sticky frame-drop flag.

Behaviour:
- Reset: `feat_o`=0, `out_index`=0, `dv_out`=0, `busy`=0, `overrun`=0. Also cleared: wr_slot=0, frames_filled=0, pending=0, state IDLE. Slot RAM contents are don't-care.
- Capture:
  - On `dv_in` with `in_index`<NCEP, write `x_i` to slot[wr_slot][in_index]. `in_index`>=NCEP is ignored.
  - Writes are by index; ordering is not checked.
- Frame completion (`dv_in` & `in_index`==NCEP-1):
  - Store `vad_in` in the slot's vad bit.
  - wr_slot <= (wr_slot+1) mod 6.
  - frames_filled saturates at 5.
  - If frames_filled reaches 5 (including this completion), an emit is triggered.
- Frame labelling: newest complete frame is t+2 = wr_slot-1 (mod 6), evaluated at trigger time. The window t-2..t+2 is slots wr_slot-5..wr_slot-1, all mod 6.
- FSM IDLE:
  - On trigger, latch the five slot pointers, go to EMIT, set busy.
  - On the cycle after a trigger at edge C, EMIT is entered (C+1), and the first `dv_out` is registered high at C+2.
- FSM EMIT:
  - Element e = 0..23 is presented.
  - e<NCEP: `feat_o` = sext(c[t][e]).
  - e>=NCEP, k=e-NCEP: `feat_o` = 2*(c[t+2][k]-c[t-2][k]) + (c[t+1][k]-c[t-1][k]), full W+3 signed, no scaling or rounding. The downstream stage applies 1/10.
  - `out_index`=e.
  - `dv_out` stays high, and `feat_o`/`out_index` stay stable, until the cycle `out_ready` is high. Then advance to e+1 on the next edge.
  - After e=23 is accepted: `dv_out`=0 and go to DONE.
- FSM DONE:
  - One cycle; busy drops.
  - If pending, clear it, latch the new pointers, and go to EMIT. Otherwise go to IDLE.
- Completion during EMIT/DONE:
  - If pending=0, set pending; capture into the free slot is legal.
  - If pending=1, the frame is dropped: no writes, wr_slot/frames_filled unchanged, `overrun`<=1 until rst. Subsequent samples of that frame are also dropped until the next index-NCEP-1 sample.
- Trigger and DONE on the same cycle: the pending path handles it; no frame is lost.
- `rst` mid-EMIT: outputs clear on the next edge; any in-progress vector is abandoned.

Optional Feature:
- Macro: VAD_GATE_EN.
- Defined: a vector whose centre frame t has stored vad=0 is suppressed. The FSM still passes IDLE→EMIT→DONE, but `dv_out` stays 0 and the elements advance one per cycle regardless of `out_ready`. History is updated normally.
- Undefined: `vad_in` and the stored vad bits are ignored; every triggered vector is emitted.

Test Plan:
- 4 frames, all coefficients 7 → no `dv_out`. 5th frame → 24 outputs: indices 0..11 =7, indices 12..23 =0, first `dv_out` 2 cycles after its index-11 sample.
- Ramp c[f][k]=100*f+k, 7 frames, out_ready=1 → 3 vectors. Vector 1 static = 200+k; all deltas = 2*400+200 = 1000.
- Extremes: c[t+2]=2^31-1, c[t-2]=-2^31, others 0 → delta = 2^33-2, no wrap in the 35-bit output.
- Backpressure: out_ready toggled 1,0,0,1,... → each value held stable while not accepted; no index skipped or duplicated; 24 handshakes.
- With out_ready=0, complete 2 extra frames after the trigger → first raises pending; second sets `overrun`=1 and is not written. Release out_ready → two full vectors, then idle.
- VAD_GATE_EN defined, centre frame vad=0 → zero `dv_out` for that vector, busy high ~26 cycles. Next frame with vad=1 → normal vector. Assert rst mid-vector → all outputs 0 next cycle; 5 fresh frames are needed before output resumes.
